bram_rd_arbiter: RTL and testbench
==================================

// Module: bram_rd_arbiter
// PURPOSE
//  Shares the single read port (B) of one simple-dual-port BRAM among NREQ requesters
//  (conv line fetch, dense weight fetch, debug readback) using round-robin with an optional lock.
//  Passes one writer through to port A.
//  Returns tagged read data one cycle after grant, with write-first forwarding on same-address collisions.
//  Sits between the CNN engines and a bram_sdp instance.
// PARAMETERS
//  NREQ   4     number of read requesters (2..8)
//  DW     16    data width, signed
//  DEPTH  1024  BRAM words
//  AW     $clog2(DEPTH) (1 if DEPTH<=1)  address width, derived
//  IW     $clog2(NREQ)  requester-id width, derived
// PORTS
//  clk      in   1        single clock, rising edge
//  rst_n    in   1        asynchronous active-low reset
//  req      in   NREQ     read request per requester, level, held until gnt
//  lock     in   NREQ     hold the grant while own req stays high (burst)
//  addr     in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  gnt      out  NREQ     one-hot; the address is accepted this cycle
//  rvalid   out  1        read data valid (1 cycle after gnt)
//  rid      out  IW       requester index owning rdata
//  rdata    out  DW       signed read data
//  wr_en    in   1        write strobe
//  wr_addr  in   AW       write address
//  wr_data  in   DW       signed write data
//  a_en, a_we  out 1      to BRAM port A (both = wr_en)
//  a_addr   out  AW       = wr_addr
//  a_din    out  DW       = wr_data
//  b_en     out  1        to BRAM port B, = |gnt
//  b_addr   out  AW       addr of granted requester (0 when idle)
//  b_dout   in   DW       BRAM read data, valid the cycle after b_en
// BEHAVIOUR
//  - Reset (async assert, sync release): rr_ptr=0, lock_owner invalid, inflight invalid,
//    fwd=0; rvalid=0, rid=0, rdata=0. gnt and b_en are combinational from req, so they are 0
//    once req is low.
//  - Port A is pure combinational passthrough; the arbiter never blocks writes.
//  - Grant (combinational): if lock_owner is valid and req[owner]=1 -> gnt=owner.
//    Otherwise the first set req scanning from rr_ptr+1 upward, mod NREQ. No req -> gnt=0.
//  - On each grant edge: rr_ptr<=granted index.
//    - If lock[g]=1, lock_owner<=g. Otherwise lock_owner is invalid.
//    - Owner dropping req releases the lock in that same cycle; normal scan applies.
//  - Latency: gnt in cycle N -> rvalid=1, rid=g, rdata in cycle N+1. Back-to-back grants
//    give rvalid every cycle. No response backpressure; requesters must accept rdata.
//  - Collision: wr_en=1 and b_en=1 with wr_addr==b_addr in cycle N -> rdata in N+1 = wr_data
//    captured in N (write-first), not b_dout.
//    - Flag fwd and the data are registered.
//    - rdata = fwd ? fwd_data : b_dout, muxed combinationally in N+1.
//    - A write in N+1 does not affect the N+1 response.
//  - rvalid/rid are registered. rdata is the fwd/b_dout mux and holds its last value while rvalid=0.
//  - Starvation bound: without lock, a waiting requester is granted within NREQ cycles.
//  - Reset mid-read: the in-flight response is dropped (rvalid=0 after reset); rr_ptr=0.
//  - Out-of-range addr (>=DEPTH) is passed through unchecked; the simulation assertion fires.
// STRUCTURE
//  - Package cnn_mem_pkg: DW/DEPTH defaults, an addr_t/data_t typedef helper, and
//    function clog2_min1().
//  - Sub-module rr_arbiter #(N) (req, lock, gnt, ptr/owner state) is instantiated once.
//  - The response pipe and forwarding stay in this module.
// TESTING
//  1 Reset: rst_n=0 with req=4'b1111 -> rvalid=0, rdata=0; after release, first gnt=4'b0010
//    (scan from rr_ptr+1=1).
//  2 RR fairness: req=4'b1111 for 8 cycles -> gnt sequence 1,2,3,0,1,2,3,0. rid matches one
//    cycle later with data mem[addr_i].
//  3 Lock: req0 with lock0=1 for 5 cycles and req1 high -> gnt0 for 5 cycles; req0 drops
//    -> gnt1 the same cycle.
//  4 Collision: preload mem[7]=100; same cycle wr 7<=-5 and requester 2 reads 7 -> next
//    cycle rvalid=1, rid=2, rdata=-5.
//  5 Non-collision write: wr 8<=42 while reading 9 (=11) -> rdata=11; a later read of 8
//    returns 42.
//  6 Mid-read reset: gnt in N, rst_n low in N+1 -> rvalid stays 0; no stale rid after
//    release. Scoreboard compares every rvalid against the reference model.

Source files
------------

// File: rtl/cnn_mem_pkg.sv
// Shared memory-side defaults and helpers for the CNN BRAM access blocks.
package cnn_mem_pkg;

  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 1024;

  // Width needed to index n items, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int AW_DEF = clog2_min1(DEPTH_DEF);

  typedef logic        [AW_DEF-1:0] addr_t;
  typedef logic signed [DW_DEF-1:0] data_t;

endpackage

// File: rtl/bram_rd_arbiter_chk.sv
// Simulation checks on the BRAM port B request stream.
module bram_rd_arbiter_chk #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input logic          clk,
  input logic          rst_n,
  input logic          b_en,
  input logic [AW-1:0] b_addr
);

  // A granted read must address a word that exists in the BRAM.
  a_addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    b_en |-> ({1'b0, b_addr} < (AW+1)'(DEPTH)));

endmodule

// File: rtl/bram_rd_arbiter_rr.sv
// Round-robin arbiter with burst lock: combinational one-hot grant,
// registered rotation pointer and lock owner.
module rr_arbiter
  import cnn_mem_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  lock,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gidx,
  output logic          gvalid
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic          owner_vld;
  logic [IW-1:0] cand;

  // Grant selection: a live lock owner wins, else scan upward from ptr+1.
  always_comb begin
    gnt    = '0;
    gidx   = '0;
    gvalid = 1'b0;
    cand   = '0;
    if (owner_vld && req[owner]) begin
      gidx   = owner;
      gvalid = 1'b1;
    end else begin
      for (int i = 1; i <= N; i++) begin
        cand = IW'((int'(ptr) + i) % N);
        if (!gvalid && req[cand]) begin
          gidx   = cand;
          gvalid = 1'b1;
        end else begin
          gvalid = gvalid;
        end
      end
    end
    if (gvalid) begin
      gnt[gidx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // Pointer follows the last winner; lock is taken only by a winner asking for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
    end else if (gvalid) begin
      ptr       <= gidx;
      owner     <= gidx;
      owner_vld <= lock[gidx];
    end else begin
      owner_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_rd_arbiter.sv
// Shares BRAM read port B among NREQ requesters, passes the writer to port A,
// and returns tagged read data one cycle after grant with write-first forwarding.
module bram_rd_arbiter
  import cnn_mem_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = clog2_min1(DEPTH),
  localparam int IW   = clog2_min1(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic                 rvalid,
  output logic [IW-1:0]        rid,
  output logic signed [DW-1:0] rdata,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  output logic                 a_en,
  output logic                 a_we,
  output logic [AW-1:0]        a_addr,
  output logic signed [DW-1:0] a_din,
  output logic                 b_en,
  output logic [AW-1:0]        b_addr,
  input  logic signed [DW-1:0] b_dout
);

  logic [IW-1:0]        gidx;
  logic                 gvalid;
  logic                 collide;
  logic                 fwd;
  logic signed [DW-1:0] fwd_data;
  logic signed [DW-1:0] rd_mux;
  logic signed [DW-1:0] rdata_hold;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .lock   (lock),
    .gnt    (gnt),
    .gidx   (gidx),
    .gvalid (gvalid)
  );

  bram_rd_arbiter_chk #(.AW(AW), .DEPTH(DEPTH)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .b_en   (b_en),
    .b_addr (b_addr)
  );

  // Writes go straight through; the arbiter never stalls port A.
  assign a_en   = wr_en;
  assign a_we   = wr_en;
  assign a_addr = wr_addr;
  assign a_din  = wr_data;
  assign b_en   = gvalid;

  // Route the winner's address to port B; park at zero when idle.
  always_comb begin
    b_addr = '0;
    if (gvalid) begin
      b_addr = addr[int'(gidx)*AW +: AW];
    end else begin
      b_addr = '0;
    end
  end

  assign collide = gvalid && wr_en && (wr_addr == b_addr);

  // Response pipe: valid/id one cycle after grant, plus captured write data on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid   <= 1'b0;
      rid      <= '0;
      fwd      <= 1'b0;
      fwd_data <= '0;
    end else begin
      rvalid <= gvalid;
      fwd    <= collide;
      if (gvalid) begin
        rid <= gidx;
      end
      if (collide) begin
        fwd_data <= wr_data;
      end
    end
  end

  // Keep the last delivered word so rdata is stable between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold <= '0;
    end else if (rvalid) begin
      rdata_hold <= rd_mux;
    end
  end

  // Write-first: a same-cycle write to the read address overrides the BRAM's old word.
  always_comb begin
    rd_mux = fwd ? fwd_data : b_dout;
    if (rvalid) begin
      rdata = rd_mux;
    end else begin
      rdata = rdata_hold;
    end
  end

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed bench for bram_rd_arbiter with a behavioural BRAM on ports A/B.
module tb_bram_rd_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int IW    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ-1:0]      gnt;
  logic                 rvalid;
  logic [IW-1:0]        rid;
  logic signed [DW-1:0] rdata;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 a_en;
  logic                 a_we;
  logic [AW-1:0]        a_addr;
  logic signed [DW-1:0] a_din;
  logic                 b_en;
  logic [AW-1:0]        b_addr;
  logic signed [DW-1:0] b_dout;

  logic signed [DW-1:0] mem     [DEPTH];
  logic signed [DW-1:0] ref_mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  logic                 pend_v;
  int                   pend_id;
  logic signed [DW-1:0] pend_data;
  logic signed [DW-1:0] last_data;

  always #5 clk = ~clk;

  bram_rd_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .lock    (lock),
    .addr    (addr),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rid     (rid),
    .rdata   (rdata),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .a_en    (a_en),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_din   (a_din),
    .b_en    (b_en),
    .b_addr  (b_addr),
    .b_dout  (b_dout)
  );

  // Simple-dual-port BRAM: read returns the pre-write word on a same-address collision.
  always @(posedge clk) begin
    if (a_en && a_we) mem[a_addr] <= a_din;
    if (b_en) b_dout <= mem[b_addr];
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_addr(input int a0, input int a1, input int a2, input int a3);
    addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  // One clock window: drive, check grant and the previous window's response, advance.
  task automatic cycle(input logic [3:0] r, input logic [3:0] lk, input logic [3:0] eg,
                       input logic we, input int wa, input int wd);
    int g;
    logic [AW-1:0] ga;
    req     = r;
    lock    = lk;
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = DW'(wd);
    #1;
    check("gnt", gnt, eg);
    check("rvalid", rvalid, pend_v);
    if (pend_v) begin
      check("rid", rid, pend_id);
      check("rdata", rdata, pend_data);
      last_data = pend_data;
    end else begin
      check("rdata_hold", rdata, last_data);
    end
    check("a_en", a_en, we);
    if (we) check("a_addr", a_addr, wa);
    g = -1;
    for (int i = 0; i < NREQ; i++) if (eg[i]) g = i;
    if (g >= 0) begin
      ga = addr[g*AW +: AW];
      check("b_addr", b_addr, ga);
      pend_v    = 1'b1;
      pend_id   = g;
      pend_data = (we && AW'(wa) == ga) ? DW'(wd) : ref_mem[ga];
    end else begin
      check("b_addr", b_addr, 0);
      pend_v = 1'b0;
    end
    if (we) ref_mem[AW'(wa)] = DW'(wd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'(i + 2);
      ref_mem[i] = DW'(i + 2);
    end
    mem[7]     = 16'sd100;
    ref_mem[7] = 16'sd100;
    pend_v    = 1'b0;
    pend_id   = 0;
    pend_data = '0;
    last_data = '0;

    // Reset with all requesters asking.
    rst_n   = 1'b0;
    req     = 4'b1111;
    lock    = 4'b0000;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    set_addr(20, 21, 22, 23);
    #12;
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rid", rid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin fairness: 1,2,3,0,1,2,3,0.
    cycle(4'b1111, 4'b0000, 4'b0010, 1'b0, 0, 0);
    cycle(4'b1111, 4'b0000, 4'b0100, 1'b0, 0, 0);
    cycle(4'b1111, 4'b0000, 4'b1000, 1'b0, 0, 0);
    cycle(4'b1111, 4'b0000, 4'b0001, 1'b0, 0, 0);
    cycle(4'b1111, 4'b0000, 4'b0010, 1'b0, 0, 0);
    cycle(4'b1111, 4'b0000, 4'b0100, 1'b0, 0, 0);
    cycle(4'b1111, 4'b0000, 4'b1000, 1'b0, 0, 0);
    cycle(4'b1111, 4'b0000, 4'b0001, 1'b0, 0, 0);

    // Lock: requester 0 holds for 5 grants while 1 waits; release hands to 1 at once.
    cycle(4'b0001, 4'b0001, 4'b0001, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(4'b0011, 4'b0001, 4'b0001, 1'b0, 0, 0);
    cycle(4'b0010, 4'b0000, 4'b0010, 1'b0, 0, 0);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0);

    // Collision: write 7<=-5 while requester 2 reads 7; next-cycle write must not leak.
    set_addr(20, 21, 7, 23);
    cycle(4'b0100, 4'b0000, 4'b0100, 1'b1, 7, -5);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 7, 55);

    // Non-colliding write: write 8<=42 while reading 9, then read 8.
    set_addr(20, 9, 7, 8);
    cycle(4'b0010, 4'b0000, 4'b0010, 1'b1, 8, 42);
    cycle(4'b1000, 4'b0000, 4'b1000, 1'b0, 0, 0);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0);

    // Mid-read reset: grant, then reset before the response appears.
    set_addr(30, 21, 31, 23);
    cycle(4'b0001, 4'b0000, 4'b0001, 1'b0, 0, 0);
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", rvalid, 0);
    check("midrst_rdata", rdata, 0);
    pend_v    = 1'b0;
    last_data = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_rid", rid, 0);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0);
    cycle(4'b0101, 4'b0000, 4'b0100, 1'b0, 0, 0);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
